uart_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 99 +++++++++
 rtl/uart_boot_loader.sv | 139 +++++++++++++
 tb/tb_uart_boot_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  // Boot FSM states
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  // UART receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hB0;

  // start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
//
// Output handshake: rx_valid is a one-cycle pulse with no ready/back-pressure.
// rx_byte and rx_frame_err are valid only in the cycle rx_valid is high.
// The consumer must accept the byte in that cycle.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;

  assign rx_s = sync[1];

  // Two-flop synchronizer for the asynchronous serial line (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  // Bit timer, start-bit validation, shift register and stop-bit check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RX_IDLE;
      rx_prev      <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_prev  <= rx_s;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at its midpoint was a glitch
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (rx_s) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_BITS;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_BITS: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'(UART_DATA_BITS - 1)) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt          <= '0;
            rx_valid     <= 1'b1;
            rx_byte      <= shift;
            rx_frame_err <= ~rx_s;
            state        <= RX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a program image over UART, writes it as 32-bit little-endian
// words to memory and releases core reset once the XOR checksum matches.
// Frame: MAGIC, N (4 bytes LE), N*4 data bytes, checksum (XOR of data bytes).
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 16384,
  parameter logic [7:0]  MAGIC        = DEFAULT_MAGIC
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        uart_rx_i,
  output logic        core_rst_n_o,
  output logic [3:0]  mem_write_enable_o,
  output logic [31:0] mem_data_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        boot_done_o,
  output logic        boot_error_o
);

  localparam int          IW      = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_frame_err;

  boot_state_t   state;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] word_idx;
  logic [31:0]   n_words;
  logic [23:0]   asm_word;
  logic [7:0]    csum;

  logic [31:0]   len_next;
  logic [31:0]   idx_next;
  logic [31:0]   word_addr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .rx          (uart_rx_i),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  // Length arrives LSB first, so each byte shifts in from the top
  assign len_next  = {rx_byte, n_words[31:8]};
  assign idx_next  = 32'(word_idx) + 32'd1;
  assign word_addr = BASE_ADDR + (32'(word_idx) << 2);

  // Boot FSM with registered memory-port and status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      word_idx           <= '0;
      n_words            <= '0;
      asm_word           <= '0;
      csum               <= '0;
      core_rst_n_o       <= 1'b0;
      mem_write_enable_o <= 4'h0;
      mem_data_address_o <= BASE_ADDR;
      mem_write_data_o   <= '0;
      boot_done_o        <= 1'b0;
      boot_error_o       <= 1'b0;
    end else begin
      mem_write_enable_o <= 4'h0;
      if (rx_valid) begin
        if (rx_frame_err) begin
          // Corrupt bytes abort an active frame; otherwise they are dropped
          if (state == LEN || state == DATA || state == CHECK) begin
            state        <= ERROR;
            boot_error_o <= 1'b1;
          end
        end else begin
          case (state)
            IDLE, ERROR: begin
              if (rx_byte == MAGIC) begin
                state        <= LEN;
                byte_cnt     <= '0;
                word_idx     <= '0;
                csum         <= '0;
                boot_error_o <= 1'b0;
              end
            end
            LEN: begin
              n_words  <= len_next;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (len_next > MAX_W32) begin
                  state        <= ERROR;
                  boot_error_o <= 1'b1;
                end else if (len_next == 32'd0) begin
                  state <= CHECK;
                end else begin
                  state <= DATA;
                end
              end
            end
            DATA: begin
              csum     <= csum ^ rx_byte;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                mem_write_enable_o <= 4'hF;
                mem_write_data_o   <= {rx_byte, asm_word};
                mem_data_address_o <= word_addr;
                word_idx           <= word_idx + IW'(1);
                if (idx_next == n_words) state <= CHECK;
              end else begin
                asm_word[{byte_cnt, 3'b000} +: 8] <= rx_byte;
              end
            end
            CHECK: begin
              if (rx_byte == csum) begin
                state        <= DONE;
                core_rst_n_o <= 1'b1;
                boot_done_o  <= 1'b1;
              end else begin
                state        <= ERROR;
                boot_error_o <= 1'b1;
              end
            end
            DONE: begin
              // Sticky until reset; further traffic is ignored
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader with a small-parameter instance.
module tb_uart_boot_loader;

  localparam int          CPB   = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          MAXW  = 4;
  localparam logic [7:0]  MAGIC = 8'hB0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  always #5 clk = ~clk;

  logic        core_rst_n;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        boot_done;
  logic        boot_error;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE),
    .MAX_WORDS   (MAXW),
    .MAGIC       (MAGIC)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .uart_rx_i         (rx),
    .core_rst_n_o      (core_rst_n),
    .mem_write_enable_o(mem_we),
    .mem_data_address_o(mem_addr),
    .mem_write_data_o  (mem_data),
    .boot_done_o       (boot_done),
    .boot_error_o      (boot_error)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_rd = 0;
  int          bad_pulse = 0;
  int          rxv_cnt = 0;
  logic [3:0]  prev_we = 4'h0;
  logic [31:0] words[$];

  // Write-port monitor: records every write, flags malformed enable pulses
  always @(negedge clk) begin
    if (mem_we != 4'h0) begin
      obs_q.push_back({mem_addr, mem_data});
      if (mem_we !== 4'hF || prev_we != 4'h0) bad_pulse++;
    end
    prev_we = mem_we;
    if (dut.rx_valid) rxv_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] image_xor();
    logic [7:0] x = 8'h00;
    foreach (words[i]) x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return x;
  endfunction

  task automatic push_expected();
    foreach (words[i]) exp_q.push_back({BASE + 32'(i) * 32'd4, words[i]});
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB * (1 + $urandom_range(0, 1))) @(negedge clk);
  endtask

  task automatic send_word_le(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
  endtask

  task automatic send_body(input logic [31:0] n);
    send_byte(MAGIC, 1'b1);
    send_word_le(n);
    foreach (words[i]) send_word_le(words[i]);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // ---------------- comparisons ----------------
  task automatic check_writes(input string name);
    logic [63:0] e;
    logic [63:0] o;
    checks++;
    if (obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s write: got addr=%h data=%h expected addr=%h data=%h", name, o[63:32], o[31:0], e[63:32], e[31:0]);
      end
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    checks++;
    if (bad_pulse !== 0) begin
      errors++;
      $display("FAIL %s we_pulse: got %0d malformed pulses expected 0", name, bad_pulse);
    end
  endtask

  task automatic check_status(input string name, input logic done_exp, input logic err_exp);
    logic [3:0] got;
    logic [3:0] exp;
    got = {core_rst_n, boot_done, boot_error, |mem_we};
    exp = {done_exp, done_exp, err_exp, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s status{core_rst_n,done,err,we}: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [70:0] got;
    logic [70:0] exp;
    got = {core_rst_n, mem_we, mem_addr, mem_data, boot_done, boot_error};
    exp = {1'b0, 4'h0, BASE, 32'h0, 1'b0, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s reset_outputs: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_status("reset_released", 1'b0, 1'b0);
  endtask

  task automatic test_good_image();
    logic [7:0] chk;
    bit seen;
    do_reset();
    words.delete();
    words.push_back(32'h1234_5678);
    words.push_back(32'hDEAD_BEEF);
    // XOR of the eight data bytes of this image is 0x2A
    chk = image_xor();
    send_body(32'd2);
    seen = 1'b0;
    fork
      send_byte(chk, 1'b1);
      begin
        for (int k = 0; k < 40 * CPB && !seen; k++) begin
          @(negedge clk);
          if (dut.rx_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL good_chk_rx_valid: got timeout expected pulse");
        end else begin
          check_status("good_at_chk_valid", 1'b0, 1'b0);
          @(negedge clk);
          check_status("good_after_chk_valid", 1'b1, 1'b0);
        end
      end
    join
    push_expected();
    check_writes("good_image");
  endtask

  task automatic test_bad_checksum();
    do_reset();
    words.delete();
    words.push_back(32'h1234_5678);
    words.push_back(32'hDEAD_BEEF);
    send_body(32'd2);
    send_byte(8'h00, 1'b1);
    push_expected();
    check_writes("bad_chk");
    check_status("bad_chk", 1'b0, 1'b1);
    send_body(32'd2);
    send_byte(image_xor(), 1'b1);
    push_expected();
    check_writes("bad_chk_retry");
    check_status("bad_chk_retry", 1'b1, 1'b0);
  endtask

  task automatic test_noise();
    do_reset();
    words.delete();
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    check_status("noise_idle", 1'b0, 1'b0);
    send_body(32'd0);
    send_byte(8'h00, 1'b1);
    check_writes("noise_n0");
    check_status("noise_n0", 1'b1, 1'b0);
    do_reset();
    send_body(32'd0);
    send_byte(8'h01, 1'b1);
    check_writes("n0_badchk");
    check_status("n0_badchk", 1'b0, 1'b1);
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(MAGIC, 1'b1);
    send_word_le(32'd5);
    check_status("oversize_5", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b1);
    check_status("oversize_5_ignored", 1'b0, 1'b1);
    // Only the upper bits are large: a truncated compare would accept this
    send_byte(MAGIC, 1'b1);
    check_status("oversize_restart", 1'b0, 1'b0);
    send_word_le(32'h0100_0004);
    check_status("oversize_hi", 1'b0, 1'b1);
    check_writes("oversize");
  endtask

  task automatic test_max_words();
    do_reset();
    random_words(MAXW);
    send_body(32'(MAXW));
    send_byte(image_xor(), 1'b1);
    push_expected();
    check_writes("max_words");
    check_status("max_words", 1'b1, 1'b0);
  endtask

  task automatic test_framing();
    do_reset();
    random_words(2);
    send_byte(MAGIC, 1'b1);
    send_word_le(32'd2);
    send_byte(words[0][7:0], 1'b1);
    send_byte(words[0][15:8], 1'b1);
    send_byte(words[0][23:16], 1'b0);
    check_status("frame_err", 1'b0, 1'b1);
    send_byte(words[0][31:24], 1'b1);
    check_writes("frame_err");
    send_body(32'd2);
    send_byte(image_xor(), 1'b1);
    push_expected();
    check_writes("frame_err_retry");
    check_status("frame_err_retry", 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    int c0;
    do_reset();
    c0 = rxv_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if (rxv_cnt !== c0) begin
      errors++;
      $display("FAIL glitch_rx_valid: got %0d pulses expected 0", rxv_cnt - c0);
    end
    check_status("glitch", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    random_words(2);
    send_byte(MAGIC, 1'b1);
    send_word_le(32'd2);
    send_word_le(words[0]);
    send_byte(words[1][7:0], 1'b1);
    exp_q.push_back({BASE, words[0]});
    check_writes("mid_reset_pre");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    random_words(3);
    send_body(32'd3);
    send_byte(image_xor(), 1'b1);
    push_expected();
    check_writes("mid_reset_fresh");
    check_status("mid_reset_fresh", 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    bit good;
    logic [7:0] chk;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n = $urandom_range(0, MAXW);
      random_words(n);
      good = 1'($urandom_range(0, 1));
      chk = image_xor();
      if (!good) chk = chk ^ 8'($urandom_range(1, 255));
      send_body(32'(n));
      send_byte(chk, 1'b1);
      push_expected();
      check_writes("random");
      check_status("random", good, !good);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    random_words(2);
    send_body(32'd2);
    send_byte(image_xor(), 1'b1);
    push_expected();
    check_writes("b2b_first");
    check_status("b2b_first", 1'b1, 1'b0);
    random_words(1);
    send_body(32'd1);
    send_byte(image_xor(), 1'b1);
    check_writes("b2b_after_done");
    check_status("b2b_after_done", 1'b1, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_noise();
    test_oversize();
    test_max_words();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
